// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: size codes, FSM states,
// misalignment test and the lane extract/merge helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Size code 11 behaves exactly like a word everywhere.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H && addr_lo[0])
            mis = 1'b1;
        if (is_word(size) && addr_lo != 2'b00)
            mis = 1'b1;
        return mis;
    endfunction

    // Halfword lane uses addr[1] only, so a stray addr[0] is ignored here.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    result = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    result = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  addr_lo,
                                               input logic [1:0]  size);
        logic [31:0] result;
        result = old_word;
        case (size)
            SZ_B: result[{addr_lo, 3'b000} +: 8] = data[7:0];
            SZ_H: begin
                if (addr_lo[1])
                    result[31:16] = data[15:0];
                else
                    result[15:0] = data[15:0];
            end
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus word-memory bus of the load/store sequencer.
// slave = the sequencer side, master = execute stage plus memory side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_rw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_rw, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extended load data and read-modify-write merge word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    assign load_data  = lane_extract(rdata, addr_lo, size, uns);
    assign merge_data = lane_merge(rdata, wdata, addr_lo, size);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer FSM with request capture registers.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests bypass memory and respond with rsp_err.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    state_t      state_reg;
    state_t      state_next;

    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;

    logic        accept;
    logic        trap_req;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign bus.req_ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_req = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign trap_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg    <= 1'b0;
            size_reg  <= SZ_B;
            uns_reg   <= 1'b0;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            we_reg    <= bus.req_we;
            size_reg  <= bus.req_size;
            uns_reg   <= bus.req_unsigned;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            err_reg   <= trap_req;
        end
    end

    lsu_align u_align (
        .rdata      (bus.mem_rdata),
        .wdata      (wdata_reg),
        .addr_lo    (addr_reg[1:0]),
        .size       (size_reg),
        .uns        (uns_reg),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept)
                    state_next = trap_req ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                // Only sub-word stores need the old word before writing.
                if (we_reg && !is_word(size_reg))
                    state_next = ST_WRITE;
                else
                    state_next = ST_DONE;
            end
            ST_WRITE: state_next = ST_DONE;
            ST_DONE: begin
                if (accept)
                    state_next = trap_req ? ST_DONE : ST_ACCESS;
                else
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rw    = 1'b0;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = {addr_reg[31:2], 2'b00};
        case (state_reg)
            ST_ACCESS: begin
                if (we_reg && is_word(size_reg)) begin
                    bus.mem_rw    = 1'b1;
                    bus.mem_wdata = wdata_reg;
                end
            end
            ST_WRITE: begin
                bus.mem_rw    = 1'b1;
                bus.mem_wdata = merge_data;
            end
            default: begin
                bus.mem_rw    = 1'b0;
                bus.mem_wdata = 32'h0;
            end
        endcase
    end

    always_comb begin
        bus.rsp_valid = (state_reg == ST_DONE);
        bus.rsp_rdata = 32'h0;
        bus.rsp_err   = 1'b0;
        if (state_reg == ST_DONE) begin
            if (!we_reg && !err_reg)
                bus.rsp_rdata = load_data;
`ifdef LSU_MISALIGN_TRAP_EN
            bus.rsp_err = err_reg;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases, random traffic against a
// byte-addressed reference memory, back-to-back loads and mid-operation reset.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if bus();

    lsu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word memory: 16 words, read data one cycle after a read strobe, held on write.
    logic [31:0] mem_words [0:15];
    always @(posedge clk) begin
        if (bus.mem_rw)
            mem_words[bus.mem_addr[5:2]] <= bus.mem_wdata;
        else
            bus.mem_rdata <= mem_words[bus.mem_addr[5:2]];
    end

    int checks   = 0;
    int failures = 0;
    logic [7:0] ref_bytes [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic int eff_addr(input logic [31:0] a, input logic [1:0] s);
        int e;
        e = int'(a & 32'h3F);
        return e & ~(nbytes(s) - 1);
    endfunction

    function automatic logic [31:0] ref_load(input int e, input int n, input bit uns);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_bytes[e + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void ref_store(input int e, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++)
            ref_bytes[e + i] = d[8 * i +: 8];
    endfunction

    // One isolated request: checks accept, latency, strobes, response and pulse width.
    task automatic xact(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, input bit check_data,
                        output logic [31:0] data_o);
        bit          trap_hit;
        int          n, e, exp_lat, lat, writes;
        logic [31:0] exp_data, wr_addr, got_data;
        logic        got_err;
        trap_hit = TRAP && misal(size, addr);
        n        = nbytes(size);
        e        = eff_addr(addr, size);
        exp_lat  = trap_hit ? 1 : (we && n < 4) ? 3 : 2;
        exp_data = (we || trap_hit) ? 32'h0 : ref_load(e, n, uns);
        lat = 0; writes = 0; wr_addr = 32'h0; got_data = 32'h0; got_err = 1'b0;

        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.mem_rw) begin
                writes++;
                wr_addr = bus.mem_addr;
            end
            if (bus.rsp_valid) begin
                lat      = k;
                got_data = bus.rsp_rdata;
                got_err  = bus.rsp_err;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (check_data)
            chk({tag, "_rdata"}, got_data, exp_data);
        chk({tag, "_err"}, 32'(got_err), 32'(trap_hit));
        chk({tag, "_writes"}, 32'(writes), (we && !trap_hit) ? 32'd1 : 32'd0);
        if (writes > 0)
            chk({tag, "_waddr"}, wr_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
        if (we && !trap_hit)
            ref_store(e, n, wdata);
        data_o = got_data;
        $display("xact %s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d",
                 tag, we, size, uns, addr, wdata, lat, got_data, got_err);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_q [$];
        int          rsp_cyc [$];
        int          idx;
        bit          acc_prev;
        bit          rsp_seen;
        logic [31:0] exp_b2b;

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h00;

        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 16; w++)
            xact(1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, $sformatf("init%0d", w), 1'b1, d);

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "w_store", 1'b1, d);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "w_load", 1'b1, d);
        chk("w_load_const", d, 32'hDEADBEEF);

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "w_store2", 1'b1, d);
        xact(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, "b_store", 1'b1, d);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "b_merge", 1'b1, d);
        chk("b_merge_const", d, 32'h11AA3344);

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, "w_store3", 1'b1, d);
        xact(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, "sb_load", 1'b1, d);
        chk("sb_load_const", d, 32'hFFFFFFFF);
        xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "uh_load", 1'b1, d);
        chk("uh_load_const", d, 32'h000080FF);
        xact(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, "sh_load", 1'b1, d);
        chk("sh_load_const", d, 32'h00007F01);
        xact(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, "mis_h_load", 1'b1, d);
        chk("mis_h_const", d, TRAP ? 32'h0 : 32'h000080FF);

        for (int i = 0; i < 120; i++)
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 63)), $urandom, $sformatf("rnd%0d", i), 1'b1, d);

        // Back-to-back word loads with req_valid held high.
        for (int i = 0; i < 4; i++) exp_q.push_back(ref_load(i * 4, 4, 1'b0));
        idx = 0;
        acc_prev = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.rsp_valid) begin
                exp_b2b = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                chk($sformatf("b2b_rdata%0d", rsp_cyc.size()), bus.rsp_rdata, exp_b2b);
                $display("b2b rsp cycle=%0d rdata=%h", cyc, bus.rsp_rdata);
                rsp_cyc.push_back(cyc);
            end
            if (acc_prev) idx++;
            bus.req_valid    = (idx < 4);
            bus.req_we       = 1'b0;
            bus.req_size     = 2'd2;
            bus.req_unsigned = 1'b0;
            bus.req_addr     = 32'(idx * 4);
            acc_prev = bus.req_valid && bus.req_ready;
        end
        chk("b2b_count", 32'(rsp_cyc.size()), 32'd4);
        if (rsp_cyc.size() > 0)
            chk("b2b_first", 32'(rsp_cyc[0]), 32'd2);
        for (int i = 1; i < rsp_cyc.size(); i++)
            chk($sformatf("b2b_gap%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i - 1]), 32'd2);

        // Reset while a byte store sits in WRITE.
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "pre_rst", 1'b1, d);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h21;
        bus.req_wdata    = 32'h00000055;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_write_rw", 32'(bus.mem_rw), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_rw_drop", 32'(bus.mem_rw), 32'd0);
        chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_addr_clr", bus.mem_addr, 32'h0);
        rsp_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen = 1'b1;
        end
        chk("rst_mid_rsp_seen", 32'(rsp_seen), 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "post_rst", 1'b0, d);
        chk("post_rst_whole", 32'(d == 32'h11223344 || d == 32'h11225544), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
